// File: rtl/vga_color_sequencer_pkg.sv
// Shared constants for the VGA colour sequencer: default timing, margin widths,
// margin reset values and the fixed colour palette.
package vga_color_sequencer_pkg;

    localparam int C_DATA_WIDTH      = 12;
    localparam int C_REZ_MAX_WIDTH   = 11;
    localparam int C_HL_MARGIN_WIDTH = 8;
    localparam int C_HR_MARGIN_WIDTH = 11;
    localparam int C_VL_MARGIN_WIDTH = 4;
    localparam int C_VR_MARGIN_WIDTH = 10;

    localparam int C_H_VISIBLE = 640;
    localparam int C_H_FRONT   = 16;
    localparam int C_H_SYNC    = 96;
    localparam int C_H_BACK    = 48;
    localparam int C_V_VISIBLE = 480;
    localparam int C_V_FRONT   = 10;
    localparam int C_V_SYNC    = 2;
    localparam int C_V_BACK    = 33;

    localparam int C_DEF_HL = 112;
    localparam int C_DEF_HR = 752;
    localparam int C_DEF_VL = 13;
    localparam int C_DEF_VR = 493;

    typedef enum logic [1:0] {
        CFG_HL = 2'd0,
        CFG_HR = 2'd1,
        CFG_VL = 2'd2,
        CFG_VR = 2'd3
    } cfg_sel_e;

    function automatic logic [11:0] pal(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = 12'hF00;
            3'd1:    c = 12'h0F0;
            3'd2:    c = 12'h00F;
            3'd3:    c = 12'hFFF;
            3'd4:    c = 12'hFF0;
            3'd5:    c = 12'h0FF;
            3'd6:    c = 12'hF0F;
            default: c = 12'hAFA;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_color_sequencer_timing.sv
// Pixel/line counters with registered active-low syncs and frame strobes.
module vga_timing_counter
    import vga_color_sequencer_pkg::*;
#(
    parameter int REZ_MAX_WIDTH = C_REZ_MAX_WIDTH,
    parameter int H_VISIBLE     = C_H_VISIBLE,
    parameter int H_FRONT       = C_H_FRONT,
    parameter int H_SYNC        = C_H_SYNC,
    parameter int H_BACK        = C_H_BACK,
    parameter int V_VISIBLE     = C_V_VISIBLE,
    parameter int V_FRONT       = C_V_FRONT,
    parameter int V_SYNC        = C_V_SYNC,
    parameter int V_BACK        = C_V_BACK
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    output logic [REZ_MAX_WIDTH-1:0] count_h_o,
    output logic [REZ_MAX_WIDTH-1:0] count_v_o,
    output logic                     hsync_o,
    output logic                     vsync_o,
    output logic                     frame_start_o,
    output logic                     frame_end_o
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [REZ_MAX_WIDTH-1:0] H_LAST  = REZ_MAX_WIDTH'(H_TOTAL - 1);
    localparam logic [REZ_MAX_WIDTH-1:0] V_LAST  = REZ_MAX_WIDTH'(V_TOTAL - 1);
    localparam logic [REZ_MAX_WIDTH-1:0] HS_BEG  = REZ_MAX_WIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [REZ_MAX_WIDTH-1:0] HS_END  = REZ_MAX_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [REZ_MAX_WIDTH-1:0] VS_BEG  = REZ_MAX_WIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [REZ_MAX_WIDTH-1:0] VS_END  = REZ_MAX_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [REZ_MAX_WIDTH-1:0] h_q, h_d, v_q, v_d;
    logic                     hs_q, hs_d, vs_q, vs_d;

    // Syncs are computed from the next count so they line up with the counter value.
    always_comb begin
        h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        hs_d = !((h_d >= HS_BEG) && (h_d <= HS_END));
        vs_d = !((v_d >= VS_BEG) && (v_d <= VS_END));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign count_h_o     = h_q;
    assign count_v_o     = v_q;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign frame_start_o = (h_q == '0) && (v_q == '0);
    assign frame_end_o   = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_color_sequencer.sv
// VGA colour sequencer: timing, frame-synchronous margin commit and palette stepping.
module vga_color_sequencer
    import vga_color_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH       = C_DATA_WIDTH,
    parameter int REZ_MAX_WIDTH    = C_REZ_MAX_WIDTH,
    parameter int HL_MARGIN_WIDTH  = C_HL_MARGIN_WIDTH,
    parameter int HR_MARGIN_WIDTH  = C_HR_MARGIN_WIDTH,
    parameter int VL_MARGIN_WIDTH  = C_VL_MARGIN_WIDTH,
    parameter int VR_MARGIN_WIDTH  = C_VR_MARGIN_WIDTH,
    parameter int H_VISIBLE        = C_H_VISIBLE,
    parameter int H_FRONT          = C_H_FRONT,
    parameter int H_SYNC           = C_H_SYNC,
    parameter int H_BACK           = C_H_BACK,
    parameter int V_VISIBLE        = C_V_VISIBLE,
    parameter int V_FRONT          = C_V_FRONT,
    parameter int V_SYNC           = C_V_SYNC,
    parameter int V_BACK           = C_V_BACK,
    parameter int DEF_HL           = C_DEF_HL,
    parameter int DEF_HR           = C_DEF_HR,
    parameter int DEF_VL           = C_DEF_VL,
    parameter int DEF_VR           = C_DEF_VR,
    parameter int NUM_COLORS       = 8,
    parameter int FRAMES_PER_COLOR = 60
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Hold,
    input  logic                       Cfg_valid,
    output logic                       Cfg_ready,
    input  logic [1:0]                 Cfg_sel,
    input  logic [REZ_MAX_WIDTH-1:0]   Cfg_value,
    input  logic                       Cfg_last,
    output logic [REZ_MAX_WIDTH-1:0]   Count_h,
    output logic [REZ_MAX_WIDTH-1:0]   Count_v,
    output logic                       Hsync,
    output logic                       Vsync,
    output logic                       Frame_start,
    output logic [HL_MARGIN_WIDTH-1:0] H_left_margin,
    output logic [HR_MARGIN_WIDTH-1:0] H_right_margin,
    output logic [VL_MARGIN_WIDTH-1:0] V_left_margin,
    output logic [VR_MARGIN_WIDTH-1:0] V_right_margin,
    output logic [DATA_WIDTH-1:0]      Data,
    output logic [2:0]                 Color_idx
);
    localparam int FC_W = (FRAMES_PER_COLOR > 1) ? $clog2(FRAMES_PER_COLOR) : 1;

    logic frame_end;

    vga_timing_counter #(
        .REZ_MAX_WIDTH(REZ_MAX_WIDTH),
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .clk_i        (Clk),
        .rst_ni       (Rst),
        .count_h_o    (Count_h),
        .count_v_o    (Count_v),
        .hsync_o      (Hsync),
        .vsync_o      (Vsync),
        .frame_start_o(Frame_start),
        .frame_end_o  (frame_end)
    );

    logic [HL_MARGIN_WIDTH-1:0] hl_q, hl_d, sh_hl_q, sh_hl_d;
    logic [HR_MARGIN_WIDTH-1:0] hr_q, hr_d, sh_hr_q, sh_hr_d;
    logic [VL_MARGIN_WIDTH-1:0] vl_q, vl_d, sh_vl_q, sh_vl_d;
    logic [VR_MARGIN_WIDTH-1:0] vr_q, vr_d, sh_vr_q, sh_vr_d;
    logic                       armed_q, armed_d, accept;
    logic [FC_W-1:0]            fcnt_q, fcnt_d;
    logic [2:0]                 idx_q, idx_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;

    assign accept = Cfg_valid && !armed_q;

    // A write taken while disarmed can only arm the following frame_end,
    // since the commit decision looks at the pre-edge armed flag.
    always_comb begin
        sh_hl_d = sh_hl_q;
        sh_hr_d = sh_hr_q;
        sh_vl_d = sh_vl_q;
        sh_vr_d = sh_vr_q;
        hl_d    = hl_q;
        hr_d    = hr_q;
        vl_d    = vl_q;
        vr_d    = vr_q;
        armed_d = armed_q;
        if (frame_end && armed_q) begin
            hl_d    = sh_hl_q;
            hr_d    = sh_hr_q;
            vl_d    = sh_vl_q;
            vr_d    = sh_vr_q;
            armed_d = 1'b0;
        end
        if (accept) begin
            case (cfg_sel_e'(Cfg_sel))
                CFG_HL:  sh_hl_d = Cfg_value[HL_MARGIN_WIDTH-1:0];
                CFG_HR:  sh_hr_d = Cfg_value[HR_MARGIN_WIDTH-1:0];
                CFG_VL:  sh_vl_d = Cfg_value[VL_MARGIN_WIDTH-1:0];
                default: sh_vr_d = Cfg_value[VR_MARGIN_WIDTH-1:0];
            endcase
            if (Cfg_last) armed_d = 1'b1;
        end
    end

    always_comb begin
        fcnt_d = fcnt_q;
        idx_d  = idx_q;
        if (frame_end && !Hold) begin
            if (fcnt_q == FC_W'(FRAMES_PER_COLOR - 1)) begin
                fcnt_d = '0;
                idx_d  = (idx_q == 3'(NUM_COLORS - 1)) ? 3'd0 : idx_q + 3'd1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        data_d = DATA_WIDTH'(pal(idx_d));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            hl_q    <= HL_MARGIN_WIDTH'(DEF_HL);
            hr_q    <= HR_MARGIN_WIDTH'(DEF_HR);
            vl_q    <= VL_MARGIN_WIDTH'(DEF_VL);
            vr_q    <= VR_MARGIN_WIDTH'(DEF_VR);
            sh_hl_q <= HL_MARGIN_WIDTH'(DEF_HL);
            sh_hr_q <= HR_MARGIN_WIDTH'(DEF_HR);
            sh_vl_q <= VL_MARGIN_WIDTH'(DEF_VL);
            sh_vr_q <= VR_MARGIN_WIDTH'(DEF_VR);
            armed_q <= 1'b0;
            fcnt_q  <= '0;
            idx_q   <= 3'd0;
            data_q  <= DATA_WIDTH'(pal(3'd0));
        end else begin
            hl_q    <= hl_d;
            hr_q    <= hr_d;
            vl_q    <= vl_d;
            vr_q    <= vr_d;
            sh_hl_q <= sh_hl_d;
            sh_hr_q <= sh_hr_d;
            sh_vl_q <= sh_vl_d;
            sh_vr_q <= sh_vr_d;
            armed_q <= armed_d;
            fcnt_q  <= fcnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign Cfg_ready      = !armed_q;
    assign H_left_margin  = hl_q;
    assign H_right_margin = hr_q;
    assign V_left_margin  = vl_q;
    assign V_right_margin = vr_q;
    assign Data           = data_q;
    assign Color_idx      = idx_q;

endmodule

// File: tb/tb_vga_color_sequencer.sv
// Directed bench for vga_color_sequencer with a frame-level reference model.
module tb_vga_color_sequencer;
    localparam int HT = 14;
    localparam int VT = 7;
    localparam int FT = HT * VT;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Hold = 1'b0;
    logic        Cfg_valid = 1'b0;
    logic        Cfg_ready;
    logic [1:0]  Cfg_sel = 2'd0;
    logic [10:0] Cfg_value = '0;
    logic        Cfg_last = 1'b0;
    logic [10:0] Count_h, Count_v;
    logic        Hsync, Vsync, Frame_start;
    logic [7:0]  H_left_margin;
    logic [10:0] H_right_margin;
    logic [3:0]  V_left_margin;
    logic [9:0]  V_right_margin;
    logic [11:0] Data;
    logic [2:0]  Color_idx;

    vga_color_sequencer #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .NUM_COLORS(4), .FRAMES_PER_COLOR(2)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Hold(Hold), .Cfg_valid(Cfg_valid), .Cfg_ready(Cfg_ready),
        .Cfg_sel(Cfg_sel), .Cfg_value(Cfg_value), .Cfg_last(Cfg_last),
        .Count_h(Count_h), .Count_v(Count_v), .Hsync(Hsync), .Vsync(Vsync),
        .Frame_start(Frame_start), .H_left_margin(H_left_margin),
        .H_right_margin(H_right_margin), .V_left_margin(V_left_margin),
        .V_right_margin(V_right_margin), .Data(Data), .Color_idx(Color_idx)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: absolute cycle count, colour steps taken, margin arrays.
    int pal_tb [8] = '{'hF00, 'h0F0, 'h00F, 'hFFF, 'hFF0, 'h0FF, 'hF0F, 'hAFA};
    int mask   [4] = '{'hFF, 'h7FF, 'hF, 'h3FF};
    int defm   [4] = '{112, 752, 13, 493};
    int m_sh   [4] = '{112, 752, 13, 493};
    int m_act  [4] = '{112, 752, 13, 493};
    int mt = 0;
    int m_steps = 0;
    bit m_armed = 1'b0;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mt = 0; m_steps = 0; m_armed = 1'b0;
            m_sh = defm; m_act = defm;
        end else begin
            bit fe, acc;
            fe  = (mt % FT) == FT - 1;
            acc = Cfg_valid && !m_armed;
            if (fe && !Hold) m_steps++;
            if (fe && m_armed) begin m_act = m_sh; m_armed = 1'b0; end
            if (acc) begin
                m_sh[Cfg_sel] = int'(Cfg_value) & mask[Cfg_sel];
                if (Cfg_last) m_armed = 1'b1;
            end
            mt++;
        end
    end

    always @(negedge Clk) begin
        int h, v, ci;
        h  = mt % HT;
        v  = (mt / HT) % VT;
        ci = (m_steps / 2) % 4;
        chk("cyc_count_h", 32'(Count_h), 32'(h));
        chk("cyc_count_v", 32'(Count_v), 32'(v));
        chk("cyc_hsync", 32'(Hsync), 32'(!(h >= 10 && h <= 11)));
        chk("cyc_vsync", 32'(Vsync), 32'(v != 5));
        chk("cyc_frame_start", 32'(Frame_start), 32'(h == 0 && v == 0));
        chk("cyc_cfg_ready", 32'(Cfg_ready), 32'(!m_armed));
        chk("cyc_hl", 32'(H_left_margin), 32'(m_act[0]));
        chk("cyc_hr", 32'(H_right_margin), 32'(m_act[1]));
        chk("cyc_vl", 32'(V_left_margin), 32'(m_act[2]));
        chk("cyc_vr", 32'(V_right_margin), 32'(m_act[3]));
        chk("cyc_color_idx", 32'(Color_idx), 32'(ci));
        chk("cyc_data", 32'(Data), 32'(pal_tb[ci]));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic to_phase(input int ph);
        int k = 0;
        step(1);
        while ((mt % FT) != ph && k < 3 * FT) begin
            step(1);
            k++;
        end
        chk("wait_bound", 32'(mt % FT), 32'(ph));
    endtask

    task automatic cfg(input int sel, input int val, input bit last);
        Cfg_valid = 1'b1;
        Cfg_sel   = sel[1:0];
        Cfg_value = val[10:0];
        Cfg_last  = last;
        step(1);
        Cfg_valid = 1'b0;
        Cfg_last  = 1'b0;
    endtask

    int exp_data [9] = '{'hF00, 'hF00, 'h0F0, 'h0F0, 'h00F, 'h00F, 'hFFF, 'hFFF, 'hF00};

    initial begin
        step(3);
        chk("rst_count_h", 32'(Count_h), 32'd0);
        chk("rst_sync", {30'd0, Hsync, Vsync}, 32'd3);
        chk("rst_frame_start", 32'(Frame_start), 32'd1);
        chk("rst_data", 32'(Data), 32'hF00);
        chk("rst_margins", {H_left_margin, V_right_margin}, {8'd112, 10'd493});
        Rst = 1'b1;

        // 1: counters and syncs
        step(10);  chk("t1_h10", 32'(Count_h), 32'd10); chk("t1_hs_lo", 32'(Hsync), 32'd0);
        step(2);   chk("t1_h12", 32'(Count_h), 32'd12); chk("t1_hs_hi", 32'(Hsync), 32'd1);
        step(58);  chk("t1_v5", 32'(Count_v), 32'd5);   chk("t1_vs_lo", 32'(Vsync), 32'd0);
        step(14);  chk("t1_v6", 32'(Count_v), 32'd6);   chk("t1_vs_hi", 32'(Vsync), 32'd1);
        step(13);  chk("t1_last", {Count_h[7:0], Count_v[7:0]}, {8'd13, 8'd6});
        chk("t1_fs_97", 32'(Frame_start), 32'd0);
        step(1);   chk("t1_fs_98", 32'(Frame_start), 32'd1);

        // 2: palette sequence, change exactly at Frame_start
        for (int k = 2; k <= 8; k++) begin
            step(FT - 1);
            chk("t2_data_pre", 32'(Data), 32'(exp_data[k-1]));
            step(1);
            chk("t2_data_fs", 32'(Data), 32'(exp_data[k]));
        end

        // 3: shadow writes with commit on frame_end
        step(20);
        cfg(0, 115, 1'b0);
        cfg(3, 200, 1'b1);
        chk("t3_ready_lo", 32'(Cfg_ready), 32'd0);
        step(30);
        chk("t3_margins_old", {H_left_margin, V_right_margin}, {8'd112, 10'd493});
        to_phase(0);
        chk("t3_margins_new", {H_left_margin, V_right_margin}, {8'd115, 10'd200});
        chk("t3_ready_hi", 32'(Cfg_ready), 32'd1);

        // 4: truncation, then a write landing on the frame_end edge
        step(5);
        cfg(2, 'h3FD, 1'b1);
        to_phase(0);
        chk("t4_vl", 32'(V_left_margin), 32'd13);
        chk("t4_hl_kept", 32'(H_left_margin), 32'd115);
        to_phase(FT - 1);
        cfg(1, 700, 1'b1);
        chk("t4_fe_hr_old", 32'(H_right_margin), 32'd752);
        chk("t4_fe_armed", 32'(Cfg_ready), 32'd0);
        chk("t4_data_f11", 32'(Data), 32'h0F0);
        to_phase(0);
        chk("t4_fe_hr_new", 32'(H_right_margin), 32'd700);
        chk("t4_data_f12", 32'(Data), 32'h00F);

        // 5: hold freezes frame_cnt mid-period
        step(FT);
        Hold = 1'b1;
        step(2 * FT);
        chk("t5_hold_mid", 32'(Data), 32'h00F);
        step(2 * FT);
        chk("t5_hold_end", 32'(Data), 32'h00F);
        chk("t5_hold_idx", 32'(Color_idx), 32'd2);
        Hold = 1'b0;
        step(FT);
        chk("t5_resume", 32'(Data), 32'hFFF);
        chk("t5_resume_idx", 32'(Color_idx), 32'd3);

        // 6: reset mid-frame drops an armed commit
        step(30);
        cfg(0, 50, 1'b1);
        chk("t6_armed", 32'(Cfg_ready), 32'd0);
        step(5);
        #2 Rst = 1'b0;
        #1;
        chk("t6_rst_counts", {Count_h, Count_v}, 32'd0);
        chk("t6_rst_fs", 32'(Frame_start), 32'd1);
        chk("t6_rst_data", 32'(Data), 32'hF00);
        chk("t6_rst_ready", 32'(Cfg_ready), 32'd1);
        chk("t6_rst_margins", {H_left_margin, H_right_margin, V_left_margin},
            {9'd0, 8'd112, 11'd752, 4'd13});
        step(3);
        Rst = 1'b1;
        step(FT + 3);
        chk("t6_no_commit", 32'(H_left_margin), 32'd112);
        chk("t6_vr_def", 32'(V_right_margin), 32'd493);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
